sine_nco: RTL and testbench

//  Numerically controlled oscillator front end: phase accumulator producing the

---
 rtl/sine_nco.sv | 103 ++++++++++
 tb/tb_sine_nco.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sine_nco.sv
// sine_nco: phase-accumulator NCO front end emitting a full-wave table index
// over a ready/valid handshake. Optional LFSR dither: define SINE_NCO_DITHER_EN.
module sine_nco #(
    parameter int ROM_DEPTH = 64,
    parameter int PHASE_W   = 24,
    parameter int DITHER_W  = 8,
    localparam int ADDRW    = $clog2(4 * ROM_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_load,
    input  logic [ADDRW-1:0]   phase_off,
    input  logic               sync,
    output logic [ADDRW-1:0]   id,
    output logic               id_valid,
    input  logic               id_ready,
    output logic               wrap
);

    if (PHASE_W <= ADDRW) begin : g_bad_phase_w
        $error("sine_nco: PHASE_W must exceed ADDRW");
    end
    if (DITHER_W > PHASE_W - ADDRW) begin : g_bad_dither_w
        $error("sine_nco: DITHER_W must not exceed PHASE_W-ADDRW");
    end

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [ADDRW-1:0]   id_q, id_d;
    logic               id_valid_q, id_valid_d;
    logic               wrap_q, wrap_d;
    logic [PHASE_W:0]   sum;
    logic [ADDRW-1:0]   tap;
    logic               adv;

    assign adv = en && (!id_valid_q || id_ready);

`ifdef SINE_NCO_DITHER_EN
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PHASE_W-1:0] dith_acc;

    // Galois form, taps 16,14,13,11; dither only perturbs the tap, never the accumulator.
    assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign dith_acc = acc_q + (PHASE_W'(lfsr_q[DITHER_W-1:0]) << (PHASE_W - ADDRW - DITHER_W));
    assign tap      = dith_acc[PHASE_W-1 -: ADDRW];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else if (!sync && adv) begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign tap = acc_q[PHASE_W-1 -: ADDRW];
`endif

    // NOTE: next-state logic uses blocking '=' with a default for every output
    // first, so no latch is inferred; only the always_ff below uses '<='.
    always_comb begin
        sum        = {1'b0, acc_q} + {1'b0, ftw_q};
        acc_d      = acc_q;
        id_d       = id_q;
        id_valid_d = id_valid_q;
        wrap_d     = 1'b0;
        ftw_d      = ftw_load ? ftw : ftw_q;
        if (sync) begin
            acc_d      = '0;
            id_valid_d = 1'b0;
        end else if (adv) begin
            id_d       = tap + phase_off;
            acc_d      = sum[PHASE_W-1:0];
            id_valid_d = 1'b1;
            wrap_d     = sum[PHASE_W];
        end else if (id_valid_q && id_ready) begin
            // Consumer took the sample while the oscillator is disabled.
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            ftw_q      <= '0;
            id_q       <= '0;
            id_valid_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            ftw_q      <= ftw_d;
            id_q       <= id_d;
            id_valid_q <= id_valid_d;
            wrap_q     <= wrap_d;
        end
    end

    assign id       = id_q;
    assign id_valid = id_valid_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_sine_nco.sv
// tb_sine_nco: table vectors, handshake/sync/reset sequences and a randomized
// run against an arithmetic phase model (PHASE_W=16, 256-entry index).
module tb_sine_nco;

    localparam int PW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst, en, ftw_load, sync, id_ready;
    logic [PW-1:0] ftw;
    logic [AW-1:0] phase_off;
    logic [AW-1:0] id;
    logic          id_valid, wrap;

    int n_total = 0;
    int n_bad   = 0;

    sine_nco #(.ROM_DEPTH(64), .PHASE_W(PW), .DITHER_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .ftw(ftw), .ftw_load(ftw_load),
        .phase_off(phase_off), .sync(sync), .id(id), .id_valid(id_valid),
        .id_ready(id_ready), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] ftw;
        logic [7:0]  off;
        int          k;       // sample number after sync (0 = first)
        logic [7:0]  exp_id;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[10];

    // Model state: phase as plain integer modulo 2^16.
    int m_ph, m_ftw, m_id;
    bit m_valid, m_wrap;

    initial begin
        vecs[0] = '{16'h0100, 8'd0,   0,   8'd0,   1'b0};
        vecs[1] = '{16'h0100, 8'd0,   1,   8'd1,   1'b0};
        vecs[2] = '{16'h0100, 8'd0,   255, 8'd255, 1'b1};
        vecs[3] = '{16'h0100, 8'd0,   256, 8'd0,   1'b0};
        vecs[4] = '{16'h8000, 8'd0,   1,   8'd128, 1'b1};
        vecs[5] = '{16'h8000, 8'd0,   2,   8'd0,   1'b0};
        vecs[6] = '{16'h0000, 8'd64,  5,   8'd64,  1'b0};
        vecs[7] = '{16'h0100, 8'd200, 100, 8'd44,  1'b0};
        vecs[8] = '{16'h1234, 8'd0,   3,   8'h36,  1'b0};
        vecs[9] = '{16'hFFFF, 8'd0,   1,   8'hFF,  1'b1};

        rst = 1'b1; en = 1'b0; ftw_load = 1'b0; sync = 1'b0; id_ready = 1'b1;
        ftw = '0; phase_off = '0;
        step();
        step();
        check("reset id", id, 0);
        check("reset id_valid", id_valid, 0);
        check("reset wrap", wrap, 0);
        rst = 1'b0;

        // Table vectors: sync + load together, then k+1 free-running advances.
        for (int v = 0; v < 10; v++) begin
            sync = 1'b1; ftw_load = 1'b1; ftw = vecs[v].ftw; en = 1'b0;
            step();
            check($sformatf("vec%0d sync valid", v), id_valid, 0);
            sync = 1'b0; ftw_load = 1'b0; en = 1'b1; id_ready = 1'b1;
            phase_off = vecs[v].off;
            for (int c = 0; c <= vecs[v].k; c++) step();
            check($sformatf("vec%0d id", v), id, vecs[v].exp_id);
            check($sformatf("vec%0d valid", v), id_valid, 1);
            check($sformatf("vec%0d wrap", v), wrap, vecs[v].exp_wrap);
        end

        // Back-pressure: 3 stalled cycles freeze everything, resume without skip.
        rst = 1'b1; step(); rst = 1'b0;
        ftw = 16'h0100; ftw_load = 1'b1; en = 1'b0; phase_off = '0;
        step();
        ftw_load = 1'b0; en = 1'b1; id_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check("pre-stall id", id, 4);
        id_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall id", id, 4);
            check("stall valid", id_valid, 1);
            check("stall wrap", wrap, 0);
        end
        id_ready = 1'b1;
        step();
        check("resume id", id, 5);

        // Consumed while disabled: valid drops, phase holds.
        en = 1'b0;
        step();
        check("disabled valid", id_valid, 0);
        check("disabled id", id, 5);
        en = 1'b1;
        step();
        check("re-enable id", id, 6);

        // Sync at id=37.
        for (int c = 0; c < 31; c++) step();
        check("pre-sync id", id, 37);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync valid", id_valid, 0);
        check("sync id holds", id, 37);
        step();
        check("post-sync id", id, 0);
        check("post-sync valid", id_valid, 1);
        step();
        check("post-sync id+1", id, 1);

        // Reset mid-run clears outputs and tuning word.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst id", id, 0);
        check("midrst valid", id_valid, 0);
        check("midrst wrap", wrap, 0);
        step();
        step();
        check("midrst ftw cleared id", id, 0);
        check("midrst ftw cleared wrap", wrap, 0);

        // Randomized run against the phase model.
        rst = 1'b1; step(); rst = 1'b0;
        m_ph = 0; m_ftw = 0; m_id = 0; m_valid = 0; m_wrap = 0;
        for (int c = 0; c < 3000; c++) begin
            bit adv;
            sync      = ($urandom_range(63) == 0);
            ftw_load  = ($urandom_range(15) == 0);
            ftw       = ($urandom_range(1) == 0) ? PW'($urandom_range(1024)) : PW'($urandom);
            en        = ($urandom_range(3) != 0);
            id_ready  = ($urandom_range(2) != 0);
            phase_off = AW'($urandom);
            step();
            if (sync) begin
                m_ph = 0; m_valid = 0; m_wrap = 0;
            end else begin
                adv = en && (!m_valid || id_ready);
                if (adv) begin
                    m_id    = ((m_ph / 256) + int'(phase_off)) % 256;
                    m_wrap  = (m_ph + m_ftw) >= 65536;
                    m_ph    = (m_ph + m_ftw) % 65536;
                    m_valid = 1;
                end else begin
                    m_wrap = 0;
                    if (m_valid && id_ready) m_valid = 0;
                end
            end
            if (ftw_load) m_ftw = int'(ftw);
            check("rand id", id, m_id);
            check("rand valid", id_valid, m_valid);
            check("rand wrap", wrap, m_wrap);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
